sdf_bf_stage8: RTL and testbench
================================

SDF_BF_STAGE8 -- requirements
Module: sdf_bf_stage8

Interface
REQ-001 Parameters SHALL be: DW, default 24, sample/twiddle word width; FRAC, default 8, fractional bits; DEPTH, default 8, delay-line length.
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  clock, all state updates on rising edge
  rst_n  in  1  reset, asynchronous, active-low
  in_valid  in  1  din_r/din_i carry a valid sample this cycle
  din_r  in  DW  input sample real, signed two's complement, FRAC fractional bits
  din_i  in  DW  input sample imaginary, same format
  state  in  2  phase from twiddle ROM: 0 fill, 1 butterfly, 2 twiddle-multiply
  w_r  in  DW  twiddle real from ROM, same-cycle
  w_i  in  DW  twiddle imaginary from ROM, same-cycle
  out_valid  out  1  dout_r/dout_i valid
  dout_r  out  DW  output real
  dout_i  out  DW  output imaginary

Function
REQ-003 Block SHALL be a radix-2 single-path delay-feedback butterfly stage consuming state, w_r, w_i combinationally in the cycle they are presented.
REQ-004 Shift enable en SHALL equal in_valid OR (state != 0); the DEPTH-entry complex delay line SHALL advance by one entry only when en=1.
REQ-005 Sample x SHALL equal din when in_valid=1, else zero; h SHALL denote the delay-line head (oldest entry).
REQ-006 state=0 (fill) and state=3 (treated as 0): delay-line input = x; no output produced.
REQ-007 state=1 (butterfly): output candidate = h + x; delay-line input = h - x.
REQ-008 state=2 (twiddle): output candidate = h * (w_r + j*w_i); delay-line input = x (next frame fill overlaps).
REQ-009 Complex multiply SHALL be re = h_r*w_r - h_i*w_i, im = h_r*w_i + h_i*w_r on full 2*DW-bit signed products, then arithmetic shift right by FRAC, truncated (no rounding) to DW bits.
REQ-010 Add/subtract SHALL be DW-bit two's-complement wrap-around; no saturation.
REQ-011 dout_r/dout_i SHALL be registered: latency exactly 1 cycle from the cycle with en=1 and state in {1,2}.
REQ-012 out_valid SHALL be 1 in the cycle after a cycle with en=1 and state in {1,2}, else 0; dout SHALL hold its last value when out_valid=0.
REQ-013 in_valid=0 during state 0 SHALL freeze the delay line (no zero insertion).
REQ-014 in_valid=0 during state 1 or 2 SHALL still advance the line, using x=0.

Reset
REQ-015 On rst_n=0, asynchronously: all delay-line entries 0, dout_r=0, dout_i=0, out_valid=0.
REQ-016 Reset asserted mid-frame SHALL discard all stored samples; after release the block SHALL behave as from power-up.

Structure
REQ-017 Shared package fft_pkg SHALL hold DW, FRAC, DEPTH defaults and state encodings ST_FILL=2'd0, ST_BF=2'd1, ST_TW=2'd2.
REQ-018 Complex multiply SHALL be a sub-module cmul_q (purely combinational, DW/FRAC parameters); the delay line and output register stay in sdf_bf_stage8.

Verification
REQ-019 8 samples 0x000100+j0 (state 0) then 8 samples 0x000100 (state 1) -> 8 outputs 0x000200+j0, then state 2 with x=0 -> 8 outputs 0x000000+j0.
REQ-020 8 samples 0x000100 then 8 zero samples (state 1) -> 8 outputs 0x000100; state 2 entry 0, W=0x000100+j0 -> 0x000100+j0; entry 2, W=0x0000B5+j0xFFFF4B -> 0x0000B5+j0xFFFF4B.
REQ-021 Wrap: h=0x7FFFFF, x=0x000001 in state 1 -> dout_r=0x800000, fed-back h-x=0x7FFFFE.
REQ-022 in_valid low for 3 cycles inside state 0 -> delay line unchanged, out_valid stays 0; subsequent outputs match REQ-019 values.
REQ-023 rst_n pulsed low during state 1 -> dout=0, out_valid=0 immediately; refilling with REQ-019 stimulus reproduces REQ-019 outputs.

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT stage defaults and phase encodings
//
// Purpose: default word/fraction/delay sizes and the phase encoding
//          presented by the twiddle ROM to every SDF butterfly stage.
// Ports:   none (package).

package fft_pkg;

  localparam int FFT_DW    = 24;  // sample/twiddle word width
  localparam int FFT_FRAC  = 8;   // fractional bits
  localparam int FFT_DEPTH = 8;   // delay-line length

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_BF   = 2'd1,
    ST_TW   = 2'd2,
    ST_RSV  = 2'd3   // unused code, behaves like ST_FILL on the data path
  } bf_state_e;

endpackage

// File: rtl/cmul_q.sv
// rtl/cmul_q.sv - combinational fixed-point complex multiply
//
// Purpose: p = a * b for signed Q(DW-FRAC).FRAC complex words. Full-width
//          products, arithmetic shift right by FRAC, truncated to DW bits.
// Ports:
//   a_r_i, a_i_i  in  DW  multiplicand real/imag
//   b_r_i, b_i_i  in  DW  multiplier real/imag
//   p_r_o, p_i_o  out DW  product real/imag

module cmul_q #(
  parameter int DW   = 24,
  parameter int FRAC = 8
) (
  input  logic signed [DW-1:0] a_r_i,
  input  logic signed [DW-1:0] a_i_i,
  input  logic signed [DW-1:0] b_r_i,
  input  logic signed [DW-1:0] b_i_i,
  output logic signed [DW-1:0] p_r_o,
  output logic signed [DW-1:0] p_i_o
);

  logic signed [2*DW-1:0] prod_rr;
  logic signed [2*DW-1:0] prod_ii;
  logic signed [2*DW-1:0] prod_ri;
  logic signed [2*DW-1:0] prod_ir;
  logic signed [2*DW:0]   sum_r;
  logic signed [2*DW:0]   sum_i;
  logic signed [2*DW:0]   shf_r;
  logic signed [2*DW:0]   shf_i;
  logic                   unused_bits;

  assign prod_rr = a_r_i * b_r_i;
  assign prod_ii = a_i_i * b_i_i;
  assign prod_ri = a_r_i * b_i_i;
  assign prod_ir = a_i_i * b_r_i;

  // One guard bit so the sum/difference of two products cannot overflow
  // before the shift.
  assign sum_r = (2*DW+1)'(prod_rr) - (2*DW+1)'(prod_ii);
  assign sum_i = (2*DW+1)'(prod_ri) + (2*DW+1)'(prod_ir);

  assign shf_r = sum_r >>> FRAC;
  assign shf_i = sum_i >>> FRAC;

  // Truncation: keep the low DW bits only.
  assign p_r_o = shf_r[DW-1:0];
  assign p_i_o = shf_i[DW-1:0];

  assign unused_bits = ^{shf_r[2*DW:DW], shf_i[2*DW:DW]};

endmodule

// File: rtl/sdf_bf_stage8.sv
// rtl/sdf_bf_stage8.sv - radix-2 single-path delay-feedback butterfly stage
//
// Purpose: DEPTH-entry complex feedback delay line with butterfly (h+x /
//          h-x) and twiddle-multiply phases selected by the ROM phase input.
// Ports:
//   clk, rst_n      in   1   clock (rising edge), async active-low reset
//   in_valid        in   1   din carries a valid sample
//   din_r, din_i    in   DW  input sample, signed, FRAC fractional bits
//   state           in   2   phase: 0 fill, 1 butterfly, 2 twiddle, 3 as 0
//   w_r, w_i        in   DW  twiddle factor, same-cycle from ROM
//   out_valid       out  1   dout valid (one cycle after a bf/tw cycle)
//   dout_r, dout_i  out  DW  registered output, holds when not valid

module sdf_bf_stage8
  import fft_pkg::*;
#(
  parameter int DW    = FFT_DW,
  parameter int FRAC  = FFT_FRAC,
  parameter int DEPTH = FFT_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] din_r,
  input  logic [DW-1:0] din_i,
  input  logic [1:0]    state,
  input  logic [DW-1:0] w_r,
  input  logic [DW-1:0] w_i,
  output logic          out_valid,
  output logic [DW-1:0] dout_r,
  output logic [DW-1:0] dout_i
);

  logic signed [DW-1:0] line_r_q [DEPTH];
  logic signed [DW-1:0] line_i_q [DEPTH];
  logic signed [DW-1:0] dout_r_q;
  logic signed [DW-1:0] dout_i_q;
  logic                 out_valid_q;

  bf_state_e            st;
  logic                 en;
  logic                 fire;
  logic signed [DW-1:0] x_r;
  logic signed [DW-1:0] x_i;
  logic signed [DW-1:0] h_r;
  logic signed [DW-1:0] h_i;
  logic signed [DW-1:0] mul_r;
  logic signed [DW-1:0] mul_i;
  logic signed [DW-1:0] line_in_r_d;
  logic signed [DW-1:0] line_in_i_d;
  logic signed [DW-1:0] dout_r_d;
  logic signed [DW-1:0] dout_i_d;

  assign st = bf_state_e'(state);

  // Outside the fill phase the line keeps moving even without input, so a
  // frame drains on schedule; during fill a missing sample freezes it.
  assign en   = in_valid | (state != 2'd0);
  assign fire = en & ((st == ST_BF) | (st == ST_TW));

  assign x_r = in_valid ? din_r : '0;
  assign x_i = in_valid ? din_i : '0;

  // Oldest entry sits at the far end of the shift chain.
  assign h_r = line_r_q[DEPTH-1];
  assign h_i = line_i_q[DEPTH-1];

  cmul_q #(
    .DW   (DW),
    .FRAC (FRAC)
  ) u_cmul (
    .a_r_i (h_r),
    .a_i_i (h_i),
    .b_r_i (w_r),
    .b_i_i (w_i),
    .p_r_o (mul_r),
    .p_i_o (mul_i)
  );

  always_comb begin
    line_in_r_d = x_r;
    line_in_i_d = x_i;
    dout_r_d    = dout_r_q;
    dout_i_d    = dout_i_q;
    case (st)
      ST_BF: begin
        dout_r_d    = h_r + x_r;
        dout_i_d    = h_i + x_i;
        line_in_r_d = h_r - x_r;
        line_in_i_d = h_i - x_i;
      end
      ST_TW: begin
        dout_r_d = mul_r;
        dout_i_d = mul_i;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        line_r_q[i] <= '0;
        line_i_q[i] <= '0;
      end
    end else if (en) begin
      line_r_q[0] <= line_in_r_d;
      line_i_q[0] <= line_in_i_d;
      for (int i = 1; i < DEPTH; i++) begin
        line_r_q[i] <= line_r_q[i-1];
        line_i_q[i] <= line_i_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r_q    <= '0;
      dout_i_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= fire;
      if (fire) begin
        dout_r_q <= dout_r_d;
        dout_i_q <= dout_i_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign dout_r    = dout_r_q;
  assign dout_i    = dout_i_q;

endmodule

// File: tb/tb_sdf_bf_stage8.sv
// tb/tb_sdf_bf_stage8.sv - self-checking bench for sdf_bf_stage8

module tb_sdf_bf_stage8;

  localparam int DW    = 24;
  localparam int FRAC  = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] din_r;
  logic [DW-1:0] din_i;
  logic [1:0]    state;
  logic [DW-1:0] w_r;
  logic [DW-1:0] w_i;
  logic          out_valid;
  logic [DW-1:0] dout_r;
  logic [DW-1:0] dout_i;

  int n_checks;
  int n_fail;

  // Reference: delay line as a FIFO of complex values (front = oldest).
  longint        mq_r[$];
  longint        mq_i[$];
  logic          m_v;
  logic [DW-1:0] m_r;
  logic [DW-1:0] m_i;

  sdf_bf_stage8 #(.DW(DW), .FRAC(FRAC), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .din_r     (din_r),
    .din_i     (din_i),
    .state     (state),
    .w_r       (w_r),
    .w_i       (w_i),
    .out_valid (out_valid),
    .dout_r    (dout_r),
    .dout_i    (dout_i)
  );

  always #5 clk = ~clk;

  function automatic longint sx(input longint v);
    longint m;
    m = v & ((longint'(1) << DW) - 1);
    if (m[DW-1]) m = m - (longint'(1) << DW);
    return m;
  endfunction

  task automatic model_reset();
    mq_r.delete();
    mq_i.delete();
    for (int k = 0; k < DEPTH; k++) begin
      mq_r.push_back(0);
      mq_i.push_back(0);
    end
    m_v = 1'b0;
    m_r = '0;
    m_i = '0;
  endtask

  task automatic model_step(input bit iv, input longint dr, input longint di,
                            input int st, input longint wr, input longint wi);
    longint xr, xi, hr, hi, nr, ni;
    xr = iv ? dr : 0;
    xi = iv ? di : 0;
    m_v = 1'b0;
    if (!(iv || st != 0)) return;
    hr = mq_r.pop_front();
    hi = mq_i.pop_front();
    nr = xr;
    ni = xi;
    if (st == 1) begin
      m_r = DW'(hr + xr);
      m_i = DW'(hi + xi);
      nr  = sx(hr - xr);
      ni  = sx(hi - xi);
      m_v = 1'b1;
    end else if (st == 2) begin
      m_r = DW'((hr * wr - hi * wi) >>> FRAC);
      m_i = DW'((hr * wi + hi * wr) >>> FRAC);
      m_v = 1'b1;
    end
    mq_r.push_back(nr);
    mq_i.push_back(ni);
  endtask

  task automatic drive(input bit iv, input logic [DW-1:0] dr, input logic [DW-1:0] di,
                       input logic [1:0] st, input logic [DW-1:0] wr, input logic [DW-1:0] wi);
    in_valid = iv;
    din_r    = dr;
    din_i    = di;
    state    = st;
    w_r      = wr;
    w_i      = wi;
    @(posedge clk);
    model_step(iv, sx(longint'(dr)), sx(longint'(di)), int'(st),
               sx(longint'(wr)), sx(longint'(wi)));
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; din_r = '0; din_i = '0; state = 2'd0; w_r = '0; w_i = '0;
    model_reset();
    #3;
    n_checks++;
    if ({out_valid, dout_r, dout_i} !== {1'b0, 24'h0, 24'h0}) begin
      n_fail++;
      $display("FAIL reset: got v=%0b r=%h i=%h, expected v=0 r=000000 i=000000",
               out_valid, dout_r, dout_i);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Fill with 0x100, butterfly with 0x100, then twiddle with no input.
  task automatic run_fill_bf_tw(input string tag, input bit stall);
    int filled;
    filled = 0;
    for (int c = 0; filled < DEPTH; c++) begin
      if (stall && c >= 2 && c <= 4) drive(1'b0, $urandom, $urandom, 2'd0, $urandom, $urandom);
      else begin
        drive(1'b1, 24'h000100, 24'h0, 2'd0, $urandom, $urandom);
        filled++;
      end
      n_checks++;
      if (out_valid !== 1'b0 || {out_valid, dout_r, dout_i} !== {m_v, m_r, m_i}) begin
        n_fail++;
        $display("FAIL %s_fill: got v=%0b r=%h i=%h, expected v=0 r=%h i=%h",
                 tag, out_valid, dout_r, dout_i, m_r, m_i);
      end
    end
    for (int c = 0; c < DEPTH; c++) begin
      drive(1'b1, 24'h000100, 24'h0, 2'd1, $urandom, $urandom);
      n_checks++;
      if ({out_valid, dout_r, dout_i} !== {1'b1, 24'h000200, 24'h0} ||
          {out_valid, dout_r, dout_i} !== {m_v, m_r, m_i}) begin
        n_fail++;
        $display("FAIL %s_bf[%0d]: got v=%0b r=%h i=%h, expected v=1 r=000200 i=000000",
                 tag, c, out_valid, dout_r, dout_i);
      end
    end
    for (int c = 0; c < DEPTH; c++) begin
      drive(1'b0, $urandom, $urandom, 2'd2, $urandom, $urandom);
      n_checks++;
      if ({out_valid, dout_r, dout_i} !== {1'b1, 24'h0, 24'h0} ||
          {out_valid, dout_r, dout_i} !== {m_v, m_r, m_i}) begin
        n_fail++;
        $display("FAIL %s_tw[%0d]: got v=%0b r=%h i=%h, expected v=1 r=000000 i=000000",
                 tag, c, out_valid, dout_r, dout_i);
      end
    end
  endtask

  task automatic test_fill_bf_tw();
    run_fill_bf_tw("basic", 1'b0);
  endtask

  task automatic test_stall_fill();
    run_fill_bf_tw("stall", 1'b1);
  endtask

  task automatic test_twiddle();
    logic [DW-1:0] wr, wi;
    for (int c = 0; c < DEPTH; c++) drive(1'b1, 24'h000100, 24'h0, 2'd0, '0, '0);
    for (int c = 0; c < DEPTH; c++) begin
      drive(1'b1, 24'h0, 24'h0, 2'd1, '0, '0);
      n_checks++;
      if ({out_valid, dout_r, dout_i} !== {1'b1, 24'h000100, 24'h0}) begin
        n_fail++;
        $display("FAIL tw_bf[%0d]: got v=%0b r=%h i=%h, expected v=1 r=000100 i=000000",
                 c, out_valid, dout_r, dout_i);
      end
    end
    for (int c = 0; c < DEPTH; c++) begin
      wr = DW'($urandom);
      wi = DW'($urandom);
      if (c == 0) begin wr = 24'h000100; wi = 24'h0; end
      if (c == 2) begin wr = 24'h0000B5; wi = 24'hFFFF4B; end
      drive(1'b0, '0, '0, 2'd2, wr, wi);
      n_checks++;
      if ({out_valid, dout_r, dout_i} !== {m_v, m_r, m_i}) begin
        n_fail++;
        $display("FAIL tw_model[%0d]: got v=%0b r=%h i=%h, expected v=%0b r=%h i=%h",
                 c, out_valid, dout_r, dout_i, m_v, m_r, m_i);
      end
      if (c == 0) begin
        n_checks++;
        if ({dout_r, dout_i} !== {24'h000100, 24'h0}) begin
          n_fail++;
          $display("FAIL tw_w0: got r=%h i=%h, expected r=000100 i=000000", dout_r, dout_i);
        end
      end
      if (c == 2) begin
        n_checks++;
        if ({dout_r, dout_i} !== {24'h0000B5, 24'hFFFF4B}) begin
          n_fail++;
          $display("FAIL tw_w2: got r=%h i=%h, expected r=0000b5 i=ffff4b", dout_r, dout_i);
        end
      end
    end
  endtask

  task automatic test_wrap();
    for (int c = 0; c < DEPTH; c++) drive(1'b1, 24'h7FFFFF, 24'h0, 2'd0, '0, '0);
    for (int c = 0; c < DEPTH; c++) begin
      drive(1'b1, 24'h000001, 24'h0, 2'd1, '0, '0);
      n_checks++;
      if ({out_valid, dout_r, dout_i} !== {1'b1, 24'h800000, 24'h0}) begin
        n_fail++;
        $display("FAIL wrap_sum[%0d]: got v=%0b r=%h i=%h, expected v=1 r=800000 i=000000",
                 c, out_valid, dout_r, dout_i);
      end
    end
    // Unity twiddle exposes the fed-back difference directly.
    for (int c = 0; c < DEPTH; c++) begin
      drive(1'b0, '0, '0, 2'd2, 24'h000100, 24'h0);
      n_checks++;
      if ({out_valid, dout_r, dout_i} !== {1'b1, 24'h7FFFFE, 24'h0}) begin
        n_fail++;
        $display("FAIL wrap_diff[%0d]: got v=%0b r=%h i=%h, expected v=1 r=7ffffe i=000000",
                 c, out_valid, dout_r, dout_i);
      end
    end
  endtask

  task automatic test_reset_midframe();
    for (int c = 0; c < DEPTH; c++) drive(1'b1, DW'($urandom), DW'($urandom), 2'd0, '0, '0);
    for (int c = 0; c < 3; c++) drive(1'b1, DW'($urandom), DW'($urandom), 2'd1, '0, '0);
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({out_valid, dout_r, dout_i} !== {1'b0, 24'h0, 24'h0}) begin
      n_fail++;
      $display("FAIL midreset: got v=%0b r=%h i=%h, expected v=0 r=000000 i=000000",
               out_valid, dout_r, dout_i);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_fill_bf_tw("after_rst", 1'b0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      drive(1'($urandom), DW'($urandom), DW'($urandom), 2'($urandom_range(0, 3)),
            DW'($urandom), DW'($urandom));
      n_checks++;
      if ({out_valid, dout_r, dout_i} !== {m_v, m_r, m_i}) begin
        n_fail++;
        $display("FAIL random[%0d]: got v=%0b r=%h i=%h, expected v=%0b r=%h i=%h",
                 c, out_valid, dout_r, dout_i, m_v, m_r, m_i);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_fill_bf_tw();
    test_twiddle();
    test_wrap();
    test_stall_fill();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
